imu_fusion_engine: RTL and testbench

//   Parametrised multi-channel successor to the fixed 2-axis IMU calc path; sits between IMUInterface and consumers.
//   Per channel: moving-average low-pass on the accel sample, gyro integration, and a complementary-filter correction.
//   One shared datapath is time-multiplexed over NUM_CH channels.

---
 rtl/imu_fusion_engine_if.sv | 25 ++
 rtl/imu_fusion_engine.sv | 160 ++++++++++++++++
 tb/tb_imu_fusion_engine.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imu_fusion_engine_if.sv
// Sample/result bundle between the IMU front end and the fusion engine.
// The producer takes master and the engine takes slave.
interface imu_fusion_engine_if #(
  parameter int NUM_CH = 2,
  parameter int W      = 10
);
  logic                SampleValid;
  logic [NUM_CH*W-1:0] AccelIn;
  logic [NUM_CH*W-1:0] GyroIn;
  logic                FuseEnable;
  logic [NUM_CH*W-1:0] AccelFiltOut;
  logic [NUM_CH*W-1:0] AngleOut;
  logic                DataReady;
  logic                Busy;
  logic [7:0]          OverrunCount;

  modport master (
    output SampleValid, AccelIn, GyroIn, FuseEnable,
    input  AccelFiltOut, AngleOut, DataReady, Busy, OverrunCount
  );
  modport slave (
    input  SampleValid, AccelIn, GyroIn, FuseEnable,
    output AccelFiltOut, AngleOut, DataReady, Busy, OverrunCount
  );
endinterface

// File: rtl/imu_fusion_engine.sv
// Multi-channel IMU fusion. One shared datapath is time-multiplexed over the channels.
// Each channel gets a moving-average accel filter, gyro integration and a complementary correction.
module imu_fusion_engine #(
  parameter int NUM_CH      = 2,
  parameter int W           = 10,
  parameter int AVG_LOG2    = 3,
  parameter int ALPHA_SHIFT = 4,
  parameter int GYRO_SHIFT  = 6
)(
  input  logic CLOCK_50,
  input  logic Reset_n,
  imu_fusion_engine_if.slave bus
);
  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int SW    = W + AVG_LOG2;
  localparam int AW    = W + 2;
  localparam int BUF_N = NUM_CH * DEPTH;
  localparam int BIW   = (BUF_N > 1) ? $clog2(BUF_N) : 1;
  localparam int CHW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PW    = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic signed [AW-1:0] ANG_MAX = AW'((1 << (W-1)) - 1);
  localparam logic signed [AW-1:0] ANG_MIN = AW'(-(1 << (W-1)));

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_AVG, S_FUSE, S_DONE} state_t;

  state_t state, stateNext;

  logic signed [W-1:0]  bufMem [BUF_N];
  logic signed [SW-1:0] sumQ   [NUM_CH];
  logic [PW-1:0]        ptrQ   [NUM_CH];
  logic signed [W-1:0]  filtQ  [NUM_CH];
  logic signed [W-1:0]  angQ   [NUM_CH];

  logic [CHW-1:0]       ch;
  logic [BIW-1:0]       initCnt;
  logic [NUM_CH*W-1:0]  accelLat, gyroLat;
  logic                 fuseLat;

  logic [NUM_CH*W-1:0]  filtOutQ, angOutQ;
  logic                 dataReadyQ;
  logic [7:0]           overrunQ;
  logic                 busy;

  logic                 lastCh, initLast;
  logic [BIW-1:0]       bufIdx;
  logic signed [W-1:0]  aCur, gCur, oldW, fCur, filtNext, angNext;
  logic signed [SW-1:0] sumNext;
  logic signed [AW-1:0] t1, t2;

  assign lastCh   = (ch == CHW'(NUM_CH - 1));
  assign initLast = (initCnt == BIW'(BUF_N - 1));
  assign bufIdx   = BIW'(int'(ch) * DEPTH + int'(ptrQ[ch]));
  assign aCur     = $signed(accelLat[int'(ch)*W +: W]);
  assign gCur     = $signed(gyroLat[int'(ch)*W +: W]);
  assign oldW     = bufMem[bufIdx];
  assign fCur     = filtQ[ch];

  // Running sum stays exact: it always equals the sum of the DEPTH buffered words.
  assign sumNext  = sumQ[ch] + SW'(aCur) - SW'(oldW);
  assign filtNext = W'(sumNext >>> AVG_LOG2);

  always_comb begin
    t1 = AW'(angQ[ch]) + AW'(gCur >>> GYRO_SHIFT);
    t2 = t1 + ((AW'(fCur) - t1) >>> ALPHA_SHIFT);
    if (!fuseLat)          angNext = fCur;
    else if (t2 > ANG_MAX) angNext = W'(ANG_MAX);
    else if (t2 < ANG_MIN) angNext = W'(ANG_MIN);
    else                   angNext = W'(t2);
  end

  // FSM state register
  always_ff @(posedge CLOCK_50) begin
    if (!Reset_n) state <= S_INIT;
    else          state <= stateNext;
  end

  // FSM next state
  always_comb begin
    stateNext = state;
    case (state)
      S_INIT: if (initLast) stateNext = S_IDLE;
      S_IDLE: if (bus.SampleValid) stateNext = S_AVG;
      S_AVG:  stateNext = S_FUSE;
      S_FUSE: stateNext = lastCh ? S_DONE : S_AVG;
      S_DONE: stateNext = S_IDLE;
      default: stateNext = S_INIT;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = (state != S_IDLE);
  end

  // History buffer: no reset, INIT walks it to zero one word per cycle.
  always_ff @(posedge CLOCK_50) begin
    if (Reset_n) begin
      if (state == S_INIT)     bufMem[initCnt] <= '0;
      else if (state == S_AVG) bufMem[bufIdx]  <= aCur;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!Reset_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        sumQ[i]  <= '0;
        ptrQ[i]  <= '0;
        filtQ[i] <= '0;
        angQ[i]  <= '0;
      end
      ch         <= '0;
      initCnt    <= '0;
      accelLat   <= '0;
      gyroLat    <= '0;
      fuseLat    <= 1'b0;
      filtOutQ   <= '0;
      angOutQ    <= '0;
      dataReadyQ <= 1'b0;
      overrunQ   <= '0;
    end else begin
      dataReadyQ <= 1'b0;
      if (bus.SampleValid && (state inside {S_AVG, S_FUSE, S_DONE}) && (overrunQ != 8'hFF))
        overrunQ <= overrunQ + 8'd1;
      case (state)
        S_INIT: initCnt <= initLast ? '0 : initCnt + 1'b1;
        S_IDLE: if (bus.SampleValid) begin
          accelLat <= bus.AccelIn;
          gyroLat  <= bus.GyroIn;
          fuseLat  <= bus.FuseEnable;
          ch       <= '0;
        end
        S_AVG: begin
          sumQ[ch]  <= sumNext;
          filtQ[ch] <= filtNext;
          ptrQ[ch]  <= (ptrQ[ch] == PW'(DEPTH - 1)) ? '0 : ptrQ[ch] + 1'b1;
        end
        S_FUSE: begin
          angQ[ch] <= angNext;
          if (lastCh) begin
            // Publish all channels together, folding in the angle finished this cycle.
            for (int i = 0; i < NUM_CH; i++) begin
              filtOutQ[i*W +: W] <= filtQ[i];
              angOutQ[i*W +: W]  <= (CHW'(i) == ch) ? angNext : angQ[i];
            end
            dataReadyQ <= 1'b1;
          end else begin
            ch <= ch + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.AccelFiltOut = filtOutQ;
  assign bus.AngleOut     = angOutQ;
  assign bus.DataReady    = dataReadyQ;
  assign bus.Busy         = busy;
  assign bus.OverrunCount = overrunQ;
endmodule

// File: tb/tb_imu_fusion_engine.sv
// Bench for imu_fusion_engine: a vector table, randomized samples checked against an
// arithmetic reference model, and hand-written reset, saturation and overrun sequences.
module tb_imu_fusion_engine;
  localparam int NUM_CH = 2;
  localparam int W      = 10;
  localparam int DEPTH  = 8;
  localparam int GDIV   = 64;
  localparam int ADIV   = 16;
  localparam int AMAX   = 511;
  localparam int AMIN   = -512;
  localparam int LAT    = 2*NUM_CH + 1;

  logic CLOCK_50 = 1'b0;
  logic Reset_n  = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  imu_fusion_engine_if #(.NUM_CH(NUM_CH), .W(W)) bus();
  imu_fusion_engine #(.NUM_CH(NUM_CH), .W(W), .AVG_LOG2(3), .ALPHA_SHIFT(4), .GYRO_SHIFT(6))
    dut (.CLOCK_50(CLOCK_50), .Reset_n(Reset_n), .bus(bus));

  int checks = 0;
  int failures = 0;

  int hist [NUM_CH][$];
  int modelFilt [NUM_CH];
  int modelAng  [NUM_CH];
  int stimA [NUM_CH];
  int stimG [NUM_CH];
  bit stimFuse;

  typedef struct {
    bit rst;
    int a0, a1, g0, g1;
    bit fuse;
    int f0, n0, f1, n1;
  } vec_t;
  vec_t vecs [12];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic failNow(input string name);
    checks++;
    failures++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  function automatic int floorDiv(input int a, input int b);
    int q;
    q = a / b;
    if ((a % b != 0) && ((a < 0) != (b < 0))) q--;
    return q;
  endfunction

  function automatic int chOf(input logic [NUM_CH*W-1:0] v, input int c);
    logic signed [W-1:0] s;
    s = v[c*W +: W];
    return int'(s);
  endfunction

  task automatic modelReset();
    for (int c = 0; c < NUM_CH; c++) begin
      hist[c].delete();
      repeat (DEPTH) hist[c].push_back(0);
      modelFilt[c] = 0;
      modelAng[c]  = 0;
    end
  endtask

  task automatic modelStep();
    int s, t;
    for (int c = 0; c < NUM_CH; c++) begin
      hist[c].push_back(stimA[c]);
      hist[c].delete(0);
      s = 0;
      for (int i = 0; i < hist[c].size(); i++) s += hist[c][i];
      modelFilt[c] = floorDiv(s, DEPTH);
      if (stimFuse) begin
        t = modelAng[c] + floorDiv(stimG[c], GDIV);
        t = t + floorDiv(modelFilt[c] - t, ADIV);
        modelAng[c] = (t > AMAX) ? AMAX : (t < AMIN) ? AMIN : t;
      end else begin
        modelAng[c] = modelFilt[c];
      end
    end
  endtask

  task automatic doReset();
    Reset_n = 1'b0;
    @(posedge CLOCK_50); #1;
    Reset_n = 1'b1;
    modelReset();
  endtask

  task automatic waitIdle(input string name);
    int n = 0;
    while (bus.Busy && n < 100) begin @(posedge CLOCK_50); #1; n++; end
    if (bus.Busy) failNow(name);
  endtask

  task automatic driveStim();
    for (int c = 0; c < NUM_CH; c++) begin
      bus.AccelIn[c*W +: W] = W'(stimA[c]);
      bus.GyroIn[c*W +: W]  = W'(stimG[c]);
    end
    bus.FuseEnable  = stimFuse;
    bus.SampleValid = 1'b1;
  endtask

  task automatic scramble();
    bus.SampleValid = 1'b0;
    bus.AccelIn     = (NUM_CH*W)'($urandom);
    bus.GyroIn      = (NUM_CH*W)'($urandom);
    bus.FuseEnable  = ~stimFuse;
  endtask

  // One complete transaction: strobe, latency, outputs vs model, pulse width.
  task automatic sendSample(input string tag);
    int lat;
    waitIdle({tag, "_idle"});
    driveStim();
    modelStep();
    @(posedge CLOCK_50); #1;
    scramble();
    lat = 1;
    while (!bus.DataReady && lat < 20) begin @(posedge CLOCK_50); #1; lat++; end
    if (!bus.DataReady) begin failNow({tag, "_dataready"}); return; end
    check({tag, "_latency"}, lat, LAT);
    for (int c = 0; c < NUM_CH; c++) begin
      check($sformatf("%s_filt_ch%0d", tag, c), chOf(bus.AccelFiltOut, c), modelFilt[c]);
      check($sformatf("%s_ang_ch%0d", tag, c), chOf(bus.AngleOut, c), modelAng[c]);
    end
    @(posedge CLOCK_50); #1;
    check({tag, "_dr_pulse"}, int'(bus.DataReady), 0);
    check({tag, "_busy_after"}, int'(bus.Busy), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, drSeen, prev0, prev1, viol, over, cur;
    int ovModel, accepts, badGap, last, decr, prevOv;

    bus.SampleValid = 1'b0;
    bus.AccelIn     = '0;
    bus.GyroIn      = '0;
    bus.FuseEnable  = 1'b0;
    modelReset();

    for (int i = 0; i < 8; i++)
      vecs[i] = '{0, 80, -8, 300, -300, 0, 10*(i+1), 10*(i+1), -(i+1), -(i+1)};
    vecs[8]  = '{1, 0, 0, 448, 0, 1, 0, 6, 0, 0};
    vecs[9]  = '{0, 0, 0, 448, 0, 1, 0, 12, 0, 0};
    vecs[10] = '{0, 0, 0, 448, -448, 1, 0, 17, 0, -7};
    vecs[11] = '{0, 64, -64, 0, 0, 0, 8, 8, -8, -8};

    // Reset, INIT length, strobes ignored during INIT
    @(posedge CLOCK_50); #1;
    Reset_n = 1'b1;
    bus.SampleValid = 1'b1;
    check("rst_filt", int'(bus.AccelFiltOut), 0);
    check("rst_angle", int'(bus.AngleOut), 0);
    check("rst_dataready", int'(bus.DataReady), 0);
    check("rst_overrun", int'(bus.OverrunCount), 0);
    n = 0; drSeen = 0;
    while (bus.Busy && n < 100) begin
      if (n == 12) bus.SampleValid = 1'b0;
      if (bus.DataReady) drSeen++;
      n++;
      @(posedge CLOCK_50); #1;
    end
    check("init_busy_cycles", n, 16);
    check("init_overrun", int'(bus.OverrunCount), 0);
    check("init_dataready", drSeen, 0);

    // Vector table: bypass ramp, fusion steps, back to bypass
    for (int i = 0; i < 12; i++) begin
      if (vecs[i].rst) begin doReset(); waitIdle("vec_rst_idle"); end
      stimA[0] = vecs[i].a0; stimA[1] = vecs[i].a1;
      stimG[0] = vecs[i].g0; stimG[1] = vecs[i].g1;
      stimFuse = vecs[i].fuse;
      sendSample($sformatf("vec%0d", i));
      check($sformatf("vec%0d_tbl_f0", i), chOf(bus.AccelFiltOut, 0), vecs[i].f0);
      check($sformatf("vec%0d_tbl_a0", i), chOf(bus.AngleOut, 0), vecs[i].n0);
      check($sformatf("vec%0d_tbl_f1", i), chOf(bus.AccelFiltOut, 1), vecs[i].f1);
      check($sformatf("vec%0d_tbl_a1", i), chOf(bus.AngleOut, 1), vecs[i].n1);
    end

    // Randomized samples with random idle gaps
    doReset();
    for (int i = 0; i < 40; i++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        stimA[c] = int'($urandom_range(0, 1023)) - 512;
        stimG[c] = int'($urandom_range(0, 1023)) - 512;
      end
      stimFuse = ($urandom_range(0, 3) != 0);
      repeat ($urandom_range(0, 3)) begin @(posedge CLOCK_50); #1; end
      sendSample($sformatf("rnd%0d", i));
    end

    // Saturation: ch0 toward +max, ch1 toward -max
    doReset();
    stimA[0] = 511; stimG[0] = 511;
    stimA[1] = -512; stimG[1] = -512;
    stimFuse = 1'b1;
    prev0 = 0; prev1 = 0; viol = 0; over = 0;
    for (int i = 0; i < 100; i++) begin
      sendSample($sformatf("sat%0d", i));
      cur = chOf(bus.AngleOut, 0);
      if (cur < prev0) viol++;
      if (cur > AMAX) over++;
      prev0 = cur;
      cur = chOf(bus.AngleOut, 1);
      if (cur > prev1) viol++;
      if (cur < AMIN) over++;
      prev1 = cur;
    end
    check("sat_monotonic_violations", viol, 0);
    check("sat_out_of_range", over, 0);
    check("sat_final_ch0", chOf(bus.AngleOut, 0), AMAX);
    check("sat_final_ch1", chOf(bus.AngleOut, 1), AMIN);

    // SampleValid held high: accept cadence and saturating overrun counter
    doReset();
    waitIdle("ovr_idle");
    stimA[0] = 100; stimA[1] = -100; stimG[0] = 64; stimG[1] = -64; stimFuse = 1'b1;
    driveStim();
    ovModel = 0; accepts = 0; badGap = 0; last = -1; decr = 0; prevOv = 0;
    for (int i = 0; i < 1000; i++) begin
      if (i == 60) check("ovr_mid_count", int'(bus.OverrunCount), ovModel);
      if (int'(bus.OverrunCount) < prevOv) decr++;
      prevOv = int'(bus.OverrunCount);
      if (!bus.Busy) begin
        if (last >= 0 && i - last != 6) badGap++;
        last = i;
        accepts++;
      end else if (ovModel < 255) begin
        ovModel++;
      end
      @(posedge CLOCK_50); #1;
    end
    bus.SampleValid = 1'b0;
    check("ovr_accepts", accepts, 167);
    check("ovr_bad_gaps", badGap, 0);
    check("ovr_saturated", int'(bus.OverrunCount), 255);
    check("ovr_model", int'(bus.OverrunCount), ovModel);
    check("ovr_no_wrap", decr, 0);
    waitIdle("ovr_drain");

    // Reset in the middle of FUSE(ch1)
    doReset();
    stimA[0] = 80; stimA[1] = 80; stimG[0] = 0; stimG[1] = 0; stimFuse = 1'b0;
    sendSample("mid_pre");
    stimFuse = 1'b1;
    driveStim();
    @(posedge CLOCK_50); #1;
    scramble();
    repeat (3) begin @(posedge CLOCK_50); #1; end
    check("mid_busy_fuse1", int'(bus.Busy), 1);
    check("mid_hold_filt", chOf(bus.AccelFiltOut, 0), 10);
    check("mid_no_dr_yet", int'(bus.DataReady), 0);
    Reset_n = 1'b0;
    @(posedge CLOCK_50); #1;
    Reset_n = 1'b1;
    modelReset();
    check("mid_rst_filt", int'(bus.AccelFiltOut), 0);
    check("mid_rst_angle", int'(bus.AngleOut), 0);
    check("mid_rst_dataready", int'(bus.DataReady), 0);
    check("mid_rst_busy", int'(bus.Busy), 1);
    n = 0; drSeen = 0;
    while (bus.Busy && n < 100) begin
      if (bus.DataReady) drSeen++;
      n++;
      @(posedge CLOCK_50); #1;
    end
    check("mid_init_cycles", n, 16);
    check("mid_dr_never", drSeen, 0);
    stimFuse = 1'b0;
    sendSample("mid_post");
    check("mid_post_filt", chOf(bus.AccelFiltOut, 0), 10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
